// File: rtl/axi_ad9680_capture_ctrl.sv
// Capture sequencer for AD9680 channel beats: arm, trigger, delay, capture, done.
// Forwarded beats are stream-qualified by dma_valid_n only; the DMA side has no backpressure.
module axi_ad9680_capture_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 adc_clk,
  input  logic                 adc_rst,
  input  logic                 cfg_arm,
  input  logic                 cfg_abort,
  input  logic [1:0]           cfg_trig_mode,
  input  logic [CNT_WIDTH-1:0] cfg_delay,
  input  logic [CNT_WIDTH-1:0] cfg_length,
  input  logic                 trig_in,
  input  logic                 adc_valid,
  input  logic                 adc_enable_0,
  input  logic                 adc_enable_1,
  input  logic [63:0]          adc_data_0,
  input  logic [63:0]          adc_data_1,
  input  logic                 adc_dovf,
  output logic                 dma_valid_0,
  output logic                 dma_valid_1,
  output logic [63:0]          dma_data_0,
  output logic [63:0]          dma_data_1,
  output logic                 dma_sync,
  output logic                 status_busy,
  output logic                 status_done,
  output logic                 status_ovf,
  output logic [CNT_WIDTH-1:0] status_count,
  output logic [2:0]           debug_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_next;
  logic                 trig_d;
  logic [1:0]           mode_q;
  logic [CNT_WIDTH-1:0] delay_cnt;
  logic [CNT_WIDTH-1:0] length_q;
  logic [CNT_WIDTH-1:0] count_inc;
  logic                 trig_hit, arm_acc, fwd, ovf_set, dly_dec;

  assign debug_state = state_q;
  assign count_inc   = status_count + ONE;

  always_comb begin
    state_next = state_q;
    arm_acc    = 1'b0;
    fwd        = 1'b0;
    ovf_set    = 1'b0;
    dly_dec    = 1'b0;
    case (mode_q)
      2'b01:   trig_hit = trig_in & ~trig_d;
      2'b10:   trig_hit = ~trig_in & trig_d;
      default: trig_hit = 1'b1;
    endcase
    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_arm) begin
          arm_acc    = 1'b1;
          state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (cfg_abort) state_next = S_DONE;
        else if (trig_hit) begin
          if (delay_cnt != '0)       state_next = S_DELAY;
          else if (length_q != '0)   state_next = S_CAPTURE;
          else                       state_next = S_DONE;
        end
      end
      S_DELAY: begin
        if (cfg_abort) state_next = S_DONE;
        else if (adc_valid) begin
          dly_dec = 1'b1;
          if (delay_cnt == ONE) state_next = (length_q != '0) ? S_CAPTURE : S_DONE;
        end
      end
      S_CAPTURE: begin
        // Overflow is recorded even when an abort takes the same cycle.
        ovf_set = adc_dovf;
        if (cfg_abort || adc_dovf) state_next = S_DONE;
        else if (adc_valid) begin
          fwd = 1'b1;
          if (count_inc == length_q) state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state_q      <= S_IDLE;
      trig_d       <= 1'b0;
      mode_q       <= 2'b00;
      delay_cnt    <= '0;
      length_q     <= '0;
      dma_valid_0  <= 1'b0;
      dma_valid_1  <= 1'b0;
      dma_data_0   <= '0;
      dma_data_1   <= '0;
      dma_sync     <= 1'b0;
      status_busy  <= 1'b0;
      status_done  <= 1'b0;
      status_ovf   <= 1'b0;
      status_count <= '0;
    end else begin
      state_q     <= state_next;
      trig_d      <= trig_in;
      status_busy <= (state_next == S_ARMED) || (state_next == S_DELAY) ||
                     (state_next == S_CAPTURE);
      status_done <= (state_next == S_DONE);
      dma_valid_0 <= fwd & adc_enable_0;
      dma_valid_1 <= fwd & adc_enable_1;
      dma_sync    <= fwd & (status_count == '0);
      if (fwd) begin
        dma_data_0 <= adc_data_0;
        dma_data_1 <= adc_data_1;
      end
      if (arm_acc) begin
        mode_q       <= cfg_trig_mode;
        delay_cnt    <= cfg_delay;
        length_q     <= cfg_length;
        status_count <= '0;
        status_ovf   <= 1'b0;
      end else begin
        if (dly_dec) delay_cnt <= delay_cnt - ONE;
        if (fwd)     status_count <= count_inc;
        if (ovf_set) status_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_ad9680_capture_ctrl.sv
// Directed bench for axi_ad9680_capture_ctrl: per-cycle vector table plus
// hand-written trigger, abort, and reset sequences checked against an expected queue.
module tb_axi_ad9680_capture_ctrl;

  localparam int W = 16;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_ARMED = 3'd1, ST_DELAY = 3'd2,
                         ST_CAP = 3'd3, ST_DONE = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_arm, cfg_abort;
  logic [1:0]    cfg_trig_mode;
  logic [W-1:0]  cfg_delay, cfg_length;
  logic          trig_in, adc_valid, adc_enable_0, adc_enable_1, adc_dovf;
  logic [63:0]   adc_data_0, adc_data_1;
  logic          dma_valid_0, dma_valid_1, dma_sync;
  logic [63:0]   dma_data_0, dma_data_1;
  logic          status_busy, status_done, status_ovf;
  logic [W-1:0]  status_count;
  logic [2:0]    debug_state;

  int total = 0;
  int bad   = 0;
  int sync_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  axi_ad9680_capture_ctrl #(.CNT_WIDTH(W)) dut (
    .adc_clk(clk), .adc_rst(rst), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .cfg_trig_mode(cfg_trig_mode), .cfg_delay(cfg_delay), .cfg_length(cfg_length),
    .trig_in(trig_in), .adc_valid(adc_valid), .adc_enable_0(adc_enable_0),
    .adc_enable_1(adc_enable_1), .adc_data_0(adc_data_0), .adc_data_1(adc_data_1),
    .adc_dovf(adc_dovf), .dma_valid_0(dma_valid_0), .dma_valid_1(dma_valid_1),
    .dma_data_0(dma_data_0), .dma_data_1(dma_data_1), .dma_sync(dma_sync),
    .status_busy(status_busy), .status_done(status_done), .status_ovf(status_ovf),
    .status_count(status_count), .debug_state(debug_state)
  );

  typedef struct {
    logic        arm, abort;
    logic [1:0]  mode;
    logic [W-1:0] delay, length;
    logic        trig, valid, en1, dovf;
    logic [63:0] d;
    logic        v0, v1, sync;
    logic [63:0] q;
    logic        busy, done, ovf;
    logic [W-1:0] cnt;
    logic [2:0]  st;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] dup(input logic [63:0] x);
    return {x[31:0], x[31:0]};
  endfunction

  function automatic vec_t mk(
    input logic arm, input logic abort, input logic [1:0] mode,
    input logic [W-1:0] delay, input logic [W-1:0] length, input logic trig,
    input logic valid, input logic en1, input logic dovf, input logic [63:0] d,
    input logic v0, input logic v1, input logic sync, input logic [63:0] q,
    input logic busy, input logic done, input logic ovf, input logic [W-1:0] cnt,
    input logic [2:0] st);
    vec_t v;
    v.arm = arm; v.abort = abort; v.mode = mode; v.delay = delay; v.length = length;
    v.trig = trig; v.valid = valid; v.en1 = en1; v.dovf = dovf; v.d = d;
    v.v0 = v0; v.v1 = v1; v.sync = sync; v.q = q; v.busy = busy; v.done = done;
    v.ovf = ovf; v.cnt = cnt; v.st = st;
    return v;
  endfunction

  // Scoreboard
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic compare_q(input string name);
    chk({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
  endtask

  always @(posedge clk) begin
    #1;
    if (dma_valid_0) got_q.push_back(dma_data_0);
    if (dma_sync) sync_cnt++;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic arm, input logic abort, input logic [1:0] mode,
                       input logic [W-1:0] delay, input logic [W-1:0] length,
                       input logic trig, input logic valid, input logic [63:0] d);
    cfg_arm = arm; cfg_abort = abort; cfg_trig_mode = mode;
    cfg_delay = delay; cfg_length = length; trig_in = trig; adc_valid = valid;
    adc_data_0 = d; adc_data_1 = dup(d);
  endtask

  task automatic check_idle_zero(input string name);
    chk({name, "_flags"}, {58'd0, dma_valid_0, dma_valid_1, dma_sync, status_busy,
        status_done, status_ovf}, 64'd0);
    chk({name, "_data0"}, dma_data_0, 64'd0);
    chk({name, "_data1"}, dma_data_1, 64'd0);
    chk({name, "_count"}, 64'(status_count), 64'd0);
    chk({name, "_state"}, 64'(debug_state), 64'(ST_IDLE));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
    adc_enable_0 = 1'b1; adc_enable_1 = 1'b1; adc_dovf = 1'b0;
    step();
    step();
    check_idle_zero("reset");
    rst = 1'b0;

    // Immediate capture, length 4
    tbl.push_back(mk(1,0,0,0,4, 0,1,1,0,0,   0,0,0,0,   1,0,0,0,ST_ARMED));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,1,   0,0,0,0,   1,0,0,0,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,2,   1,1,1,2,   1,0,0,1,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,3,   1,1,0,3,   1,0,0,2,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,4,   1,1,0,4,   1,0,0,3,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,5,   1,1,0,5,   0,1,0,4,ST_DONE));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,6,   0,0,0,5,   0,1,0,4,ST_DONE));
    // Overflow on the 6th capture beat, re-arm, then abort while armed
    tbl.push_back(mk(1,0,0,0,10,0,1,1,0,100, 0,0,0,5,   1,0,0,0,ST_ARMED));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,101, 0,0,0,5,   1,0,0,0,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,102, 1,1,1,102, 1,0,0,1,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,103, 1,1,0,103, 1,0,0,2,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,104, 1,1,0,104, 1,0,0,3,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,105, 1,1,0,105, 1,0,0,4,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,106, 1,1,0,106, 1,0,0,5,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,1,107, 0,0,0,106, 0,1,1,5,ST_DONE));
    tbl.push_back(mk(1,0,0,0,10,0,0,1,0,108, 0,0,0,106, 1,0,0,0,ST_ARMED));
    tbl.push_back(mk(0,1,0,0,0, 0,1,1,0,109, 0,0,0,106, 0,1,0,0,ST_DONE));
    // Zero length after delay 2, then length 3 with channel 1 disabled
    tbl.push_back(mk(1,0,0,2,0, 0,0,1,0,199, 0,0,0,106, 1,0,0,0,ST_ARMED));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,199, 0,0,0,106, 1,0,0,0,ST_DELAY));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,200, 0,0,0,106, 1,0,0,0,ST_DELAY));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,201, 0,0,0,106, 1,0,0,0,ST_DELAY));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,202, 0,0,0,106, 0,1,0,0,ST_DONE));
    tbl.push_back(mk(1,0,0,0,3, 0,1,0,0,300, 0,0,0,106, 1,0,0,0,ST_ARMED));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,0,301, 0,0,0,106, 1,0,0,0,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,0,302, 1,0,1,302, 1,0,0,1,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,0,303, 1,0,0,303, 1,0,0,2,ST_CAP));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,0,304, 1,0,0,304, 0,1,0,3,ST_DONE));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,0,305, 0,0,0,304, 0,1,0,3,ST_DONE));

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].arm, tbl[r].abort, tbl[r].mode, tbl[r].delay, tbl[r].length,
            tbl[r].trig, tbl[r].valid, tbl[r].d);
      adc_enable_1 = tbl[r].en1;
      adc_dovf     = tbl[r].dovf;
      step();
      chk($sformatf("row%0d_flags", r),
          {58'd0, dma_valid_0, dma_valid_1, dma_sync, status_busy, status_done, status_ovf},
          {58'd0, tbl[r].v0, tbl[r].v1, tbl[r].sync, tbl[r].busy, tbl[r].done, tbl[r].ovf});
      chk($sformatf("row%0d_data0", r), dma_data_0, tbl[r].q);
      chk($sformatf("row%0d_data1", r), dma_data_1, dup(tbl[r].q));
      chk($sformatf("row%0d_count", r), 64'(status_count), 64'(tbl[r].cnt));
      chk($sformatf("row%0d_state", r), 64'(debug_state), 64'(tbl[r].st));
    end
    adc_enable_1 = 1'b1;
    adc_dovf     = 1'b0;

    // Rising-edge trigger 5 cycles after arm, delay 3, length 2, valid toggling
    got_q.delete(); exp_q.delete(); sync_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      drive(i == 0, 0, 2'b01, 3, 2, i >= 5, (i % 2) == 0, 64'(400 + i));
      step();
    end
    trig_in = 1'b0;
    exp_q.push_back(64'd412);
    exp_q.push_back(64'd414);
    compare_q("rise_trig");
    chk("rise_trig_sync", 64'(sync_cnt), 64'd1);
    chk("rise_trig_count", 64'(status_count), 64'd2);
    chk("rise_trig_state", 64'(debug_state), 64'(ST_DONE));

    // Abort and arm together in DELAY: abort wins, nothing forwarded
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      drive(i == 0 || i == 3, i == 3, 2'b00, 5, 3, 0, 1, 64'(500 + i));
      step();
    end
    compare_q("abort_arm");
    chk("abort_arm_state", 64'(debug_state), 64'(ST_DONE));
    chk("abort_arm_status", {62'd0, status_done, status_busy}, 64'd2);
    chk("abort_arm_count", 64'(status_count), 64'd0);

    // Arm during CAPTURE is ignored; capture completes at length 3
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      drive(i == 0 || i == 3, 0, 2'b00, 0, (i == 3) ? 16'd7 : 16'd3, 0, 1, 64'(600 + i));
      step();
    end
    exp_q.push_back(64'd602);
    exp_q.push_back(64'd603);
    exp_q.push_back(64'd604);
    compare_q("arm_in_cap");
    chk("arm_in_cap_count", 64'(status_count), 64'd3);
    chk("arm_in_cap_state", 64'(debug_state), 64'(ST_DONE));
    chk("arm_in_cap_done", 64'(status_done), 64'd1);

    // Reset on the 2nd beat of an 8-beat capture
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 0, 2'b00, 0, 8, 0, 1, 64'(700 + i));
      rst = (i == 3);
      step();
    end
    rst = 1'b0;
    check_idle_zero("mid_reset");
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 2'b00, 0, 8, 0, 1, 64'(800 + i));
      step();
    end
    exp_q.push_back(64'd702);
    compare_q("mid_reset_beats");
    chk("mid_reset_after_state", 64'(debug_state), 64'(ST_IDLE));
    chk("mid_reset_after_count", 64'(status_count), 64'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
